// File: rtl/wic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wic_pkg
// Brief    : Shared types, reset constants and id-width helper for the WIC.
// Revision : 1.0
// ============================================================================
package wic_pkg;

  typedef enum logic [0:0] {
    WIC_IDLE = 1'b0,
    WIC_REQ  = 1'b1
  } wic_state_e;

  localparam wic_state_e WIC_RST_STATE = WIC_IDLE;
  localparam logic       WIC_RST_BIT   = 1'b0;

  // Index width for n channels; never below one bit.
  function automatic int wic_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wic_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : wic_prio_enc
// Brief    : Lowest-index-first priority encoder with an any-set flag.
// Revision : 1.0
// ============================================================================
module wic_prio_enc
  import wic_pkg::*;
#(
  parameter int N = 32,
  parameter int W = wic_id_w(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scanning downward lets the lowest set index overwrite higher ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wic_pend_arb.sv
`default_nettype none
// ============================================================================
// Module   : wic_pend_arb
// Brief    : Wake-up interrupt pending latch with serialising valid/ack
//            request channel. Optional WIC_IN_SYNC_EN adds a 2-flop input
//            synchroniser ahead of edge/level detection.
// Revision : 1.0
// ============================================================================
module wic_pend_arb
  import wic_pkg::*;
#(
  parameter  int NUM_INT = 32,
  localparam int ID_W    = wic_id_w(NUM_INT)
) (
  input  logic               wic_clk,
  input  logic               pad_cpu_rst_b,
  input  logic [NUM_INT-1:0] int_vld,
  input  logic [NUM_INT-1:0] int_cfg,
  input  logic [NUM_INT-1:0] int_en,
  input  logic [NUM_INT-1:0] sw_clr,
  output logic [NUM_INT-1:0] int_pending,
  output logic               intraw_vld,
  output logic               arb_req_vld,
  output logic [ID_W-1:0]    arb_req_id,
  input  logic               arb_req_ack
);

  logic [NUM_INT-1:0] vld_in;
  logic [NUM_INT-1:0] vld_hist;
  logic [NUM_INT-1:0] set_vec;
  logic [NUM_INT-1:0] clr_vec;
  logic [NUM_INT-1:0] cand;
  logic [ID_W-1:0]    win_id;
  logic               win_any;
  logic               ack_clr;
  logic               load_id;
  wic_state_e         state;
  wic_state_e         state_nxt;

`ifdef WIC_IN_SYNC_EN
  logic [NUM_INT-1:0] sync_q1;
  logic [NUM_INT-1:0] sync_q2;

  always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      sync_q1 <= {NUM_INT{WIC_RST_BIT}};
      sync_q2 <= {NUM_INT{WIC_RST_BIT}};
    end else begin
      sync_q1 <= int_vld;
      sync_q2 <= sync_q1;
    end
  end

  assign vld_in = sync_q2;
`else
  assign vld_in = int_vld;
`endif

  // Edge channels fire on 0->1 against history; level channels fire while high.
  assign set_vec = (vld_in & ~vld_hist & int_cfg) | (vld_in & ~int_cfg);
  assign clr_vec = sw_clr
                 | ({NUM_INT{ack_clr}} & ({{(NUM_INT-1){1'b0}}, 1'b1} << arb_req_id));

  always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      vld_hist    <= {NUM_INT{WIC_RST_BIT}};
      int_pending <= {NUM_INT{WIC_RST_BIT}};
    end else begin
      vld_hist    <= vld_in;
      int_pending <= (int_pending & ~clr_vec) | set_vec;
    end
  end

  assign cand       = int_pending & int_en;
  assign intraw_vld = |cand;

  wic_prio_enc #(
    .N (NUM_INT),
    .W (ID_W)
  ) u_prio (
    .req (cand),
    .idx (win_id),
    .any (win_any)
  );

  always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state <= WIC_RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_id   = 1'b0;
    case (state)
      WIC_IDLE: begin
        if (win_any) begin
          state_nxt = WIC_REQ;
          load_id   = 1'b1;
        end
      end
      WIC_REQ: begin
        if (arb_req_ack) state_nxt = WIC_IDLE;
      end
      default: state_nxt = WIC_RST_STATE;
    endcase
  end

  always_comb begin
    arb_req_vld = (state == WIC_REQ);
    ack_clr     = (state == WIC_REQ) && arb_req_ack;
  end

  // Id is captured on entry to REQ and held until the next grant.
  always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      arb_req_id <= '0;
    end else if (load_id) begin
      arb_req_id <= win_id;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wic_pend_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wic_pend_arb
// Brief    : Self-checking bench for wic_pend_arb (NUM_INT=32).
// Revision : 1.0
// ============================================================================
module tb_wic_pend_arb;

  localparam int N = 32;
`ifdef WIC_IN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          wic_clk = 1'b0;
  logic          pad_cpu_rst_b = 1'b0;
  logic [N-1:0]  int_vld = '0;
  logic [N-1:0]  int_cfg = '0;
  logic [N-1:0]  int_en  = '0;
  logic [N-1:0]  sw_clr  = '0;
  logic          arb_req_ack = 1'b0;
  logic [N-1:0]  int_pending;
  logic          intraw_vld;
  logic          arb_req_vld;
  logic [4:0]    arb_req_id;

  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_q[$];
  logic [4:0]    exp_id;

  wic_pend_arb #(.NUM_INT(N)) dut (
    .wic_clk       (wic_clk),
    .pad_cpu_rst_b (pad_cpu_rst_b),
    .int_vld       (int_vld),
    .int_cfg       (int_cfg),
    .int_en        (int_en),
    .sw_clr        (sw_clr),
    .int_pending   (int_pending),
    .intraw_vld    (intraw_vld),
    .arb_req_vld   (arb_req_vld),
    .arb_req_id    (arb_req_id),
    .arb_req_ack   (arb_req_ack)
  );

  always #5 wic_clk = ~wic_clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge wic_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    pad_cpu_rst_b = 1'b0;
    int_vld = 32'h8; int_cfg = 32'h8; int_en = '0;
    step(2);
    n_cmp++; if (int_pending !== 32'h0) begin n_err++; $display("FAIL rst_pending: got %h want %h", int_pending, 32'h0); end
    n_cmp++; if (arb_req_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", arb_req_vld); end
    n_cmp++; if (arb_req_id !== 5'd0) begin n_err++; $display("FAIL rst_id: got %0d want 0", arb_req_id); end
    n_cmp++; if (intraw_vld !== 1'b0) begin n_err++; $display("FAIL rst_intraw: got %b want 0", intraw_vld); end
    pad_cpu_rst_b = 1'b1;
    step(LAT);
    n_cmp++; if (int_pending !== 32'h8) begin n_err++; $display("FAIL rel_pending: got %h want %h", int_pending, 32'h8); end
    n_cmp++; if (intraw_vld !== 1'b0) begin n_err++; $display("FAIL rel_intraw: got %b want 0", intraw_vld); end
    step(2);
    n_cmp++; if (arb_req_vld !== 1'b0) begin n_err++; $display("FAIL rel_vld: got %b want 0", arb_req_vld); end
    int_vld = '0; sw_clr = 32'h8;
    step();
    sw_clr = '0;
    n_cmp++; if (int_pending !== 32'h0) begin n_err++; $display("FAIL rel_swclr: got %h want %h", int_pending, 32'h0); end
  endtask

  task automatic test_edge_pair();
    int_en = '1; int_cfg = '1;
    int_vld = 32'h24;
    exp_q.push_back(2); exp_q.push_back(5);
    step();
    int_vld = '0;
    step(LAT - 1);
    n_cmp++; if (int_pending !== 32'h24) begin n_err++; $display("FAIL pair_pending: got %h want %h", int_pending, 32'h24); end
    n_cmp++; if (intraw_vld !== 1'b1) begin n_err++; $display("FAIL pair_intraw: got %b want 1", intraw_vld); end
    n_cmp++; if (arb_req_vld !== 1'b0) begin n_err++; $display("FAIL pair_vld_early: got %b want 0", arb_req_vld); end
    step();
    exp_id = 5'(exp_q.pop_front());
    n_cmp++; if (arb_req_vld !== 1'b1 || arb_req_id !== exp_id) begin n_err++; $display("FAIL pair_req1: got vld=%b id=%0d want vld=1 id=%0d", arb_req_vld, arb_req_id, exp_id); end
    arb_req_ack = 1'b1; step(); arb_req_ack = 1'b0;
    n_cmp++; if (arb_req_vld !== 1'b0 || int_pending !== 32'h20) begin n_err++; $display("FAIL pair_ack1: got vld=%b pend=%h want vld=0 pend=%h", arb_req_vld, int_pending, 32'h20); end
    step();
    exp_id = 5'(exp_q.pop_front());
    n_cmp++; if (arb_req_vld !== 1'b1 || arb_req_id !== exp_id) begin n_err++; $display("FAIL pair_req2: got vld=%b id=%0d want vld=1 id=%0d", arb_req_vld, arb_req_id, exp_id); end
    arb_req_ack = 1'b1; step(); arb_req_ack = 1'b0;
    n_cmp++; if (arb_req_vld !== 1'b0 || int_pending !== 32'h0) begin n_err++; $display("FAIL pair_ack2: got vld=%b pend=%h want vld=0 pend=0", arb_req_vld, int_pending); end
    step();
    n_cmp++; if (arb_req_vld !== 1'b0) begin n_err++; $display("FAIL pair_idle: got %b want 0", arb_req_vld); end
  endtask

  task automatic test_level();
    int_cfg = ~(32'h1 << 7);
    int_vld = 32'h1 << 7;
    exp_q.push_back(7);
    step(LAT);
    n_cmp++; if (int_pending[7] !== 1'b1) begin n_err++; $display("FAIL lvl_set: got %b want 1", int_pending[7]); end
    step();
    exp_id = 5'(exp_q.pop_front());
    n_cmp++; if (arb_req_vld !== 1'b1 || arb_req_id !== exp_id) begin n_err++; $display("FAIL lvl_req1: got vld=%b id=%0d want vld=1 id=%0d", arb_req_vld, arb_req_id, exp_id); end
    arb_req_ack = 1'b1; step(); arb_req_ack = 1'b0;
    exp_q.push_back(7);
    n_cmp++; if (arb_req_vld !== 1'b0 || int_pending[7] !== 1'b1) begin n_err++; $display("FAIL lvl_hold: got vld=%b pend7=%b want vld=0 pend7=1", arb_req_vld, int_pending[7]); end
    step();
    exp_id = 5'(exp_q.pop_front());
    n_cmp++; if (arb_req_vld !== 1'b1 || arb_req_id !== exp_id) begin n_err++; $display("FAIL lvl_req2: got vld=%b id=%0d want vld=1 id=%0d", arb_req_vld, arb_req_id, exp_id); end
    int_vld = '0;
    step(LAT - 1);
    arb_req_ack = 1'b1; step(); arb_req_ack = 1'b0;
    n_cmp++; if (arb_req_vld !== 1'b0 || int_pending !== 32'h0) begin n_err++; $display("FAIL lvl_drop: got vld=%b pend=%h want vld=0 pend=0", arb_req_vld, int_pending); end
    int_cfg = '1;
    step();
  endtask

  task automatic test_sw_clr_set();
    int_en = '0;
    int_vld = 32'h4;
    step(LAT - 1);
    sw_clr = 32'h4;
    step();
    sw_clr = '0;
    n_cmp++; if (int_pending !== 32'h4) begin n_err++; $display("FAIL clrset_win: got %h want %h", int_pending, 32'h4); end
    sw_clr = 32'h4;
    step();
    sw_clr = '0;
    n_cmp++; if (int_pending !== 32'h0) begin n_err++; $display("FAIL clrset_clr: got %h want %h", int_pending, 32'h0); end
    int_vld = '0;
    step(LAT);
  endtask

  task automatic test_ack_idle();
    int_en = '0;
    int_vld = 32'h10;
    step();
    int_vld = '0;
    step(LAT - 1);
    n_cmp++; if (int_pending !== 32'h10 || intraw_vld !== 1'b0) begin n_err++; $display("FAIL idle_pend: got pend=%h raw=%b want pend=10 raw=0", int_pending, intraw_vld); end
    arb_req_ack = 1'b1; step(); arb_req_ack = 1'b0;
    n_cmp++; if (int_pending !== 32'h10 || arb_req_vld !== 1'b0) begin n_err++; $display("FAIL idle_ack: got pend=%h vld=%b want pend=10 vld=0", int_pending, arb_req_vld); end
    int_en = 32'h10;
    #1;
    n_cmp++; if (intraw_vld !== 1'b1) begin n_err++; $display("FAIL idle_raw_en: got %b want 1", intraw_vld); end
    exp_q.push_back(4);
    step();
    exp_id = 5'(exp_q.pop_front());
    n_cmp++; if (arb_req_vld !== 1'b1 || arb_req_id !== exp_id) begin n_err++; $display("FAIL idle_req: got vld=%b id=%0d want vld=1 id=%0d", arb_req_vld, arb_req_id, exp_id); end
    sw_clr = 32'h10; int_en = '0;
    step();
    sw_clr = '0;
    n_cmp++; if (int_pending !== 32'h0 || arb_req_vld !== 1'b1 || arb_req_id !== 5'd4) begin n_err++; $display("FAIL idle_stable: got pend=%h vld=%b id=%0d want pend=0 vld=1 id=4", int_pending, arb_req_vld, arb_req_id); end
    arb_req_ack = 1'b1; step(); arb_req_ack = 1'b0;
    n_cmp++; if (arb_req_vld !== 1'b0 || int_pending !== 32'h0) begin n_err++; $display("FAIL idle_stale_ack: got vld=%b pend=%h want vld=0 pend=0", arb_req_vld, int_pending); end
    int_en = '1;
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int seen = 0;
    int_vld = (32'h1 << 1) | (32'h1 << 3) | (32'h1 << 9) | (32'h1 << 20);
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(9); exp_q.push_back(20);
    step();
    int_vld = '0;
    arb_req_ack = 1'b1;
    for (int c = 0; c < 30 && seen < 4; c++) begin
      step();
      if (arb_req_vld) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL b2b_extra: got id=%0d want no request", arb_req_id);
        end else begin
          exp_id = 5'(exp_q.pop_front());
          n_cmp++; if (arb_req_id !== exp_id) begin n_err++; $display("FAIL b2b_id: got %0d want %0d", arb_req_id, exp_id); end
        end
        if (last >= 0) begin
          n_cmp++; if (c - last != 2) begin n_err++; $display("FAIL b2b_gap: got %0d want 2", c - last); end
        end
        last = c;
        seen++;
      end
    end
    step();
    arb_req_ack = 1'b0;
    n_cmp++; if (seen != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", seen); end
    n_cmp++; if (int_pending !== 32'h0 || arb_req_vld !== 1'b0) begin n_err++; $display("FAIL b2b_end: got pend=%h vld=%b want pend=0 vld=0", int_pending, arb_req_vld); end
  endtask

  task automatic test_reset_mid_req();
    int waited = 0;
    int_vld = 32'h1 << 6;
    exp_q.push_back(6);
    step();
    int_vld = '0;
    while (!arb_req_vld && waited < 10) begin
      step();
      waited++;
    end
    exp_id = 5'(exp_q.pop_front());
    n_cmp++; if (arb_req_vld !== 1'b1 || arb_req_id !== exp_id) begin n_err++; $display("FAIL mid_req: got vld=%b id=%0d want vld=1 id=%0d", arb_req_vld, arb_req_id, exp_id); end
    #2;
    pad_cpu_rst_b = 1'b0;
    #1;
    n_cmp++; if (arb_req_vld !== 1'b0 || arb_req_id !== 5'd0 || int_pending !== 32'h0 || intraw_vld !== 1'b0) begin
      n_err++; $display("FAIL mid_rst: got vld=%b id=%0d pend=%h raw=%b want all zero", arb_req_vld, arb_req_id, int_pending, intraw_vld);
    end
    step();
    pad_cpu_rst_b = 1'b1;
    step(2);
    n_cmp++; if (arb_req_vld !== 1'b0 || int_pending !== 32'h0) begin n_err++; $display("FAIL mid_after: got vld=%b pend=%h want vld=0 pend=0", arb_req_vld, int_pending); end
  endtask

  initial begin
    test_reset();
    test_edge_pair();
    test_level();
    test_sw_clr_set();
    test_ack_idle();
    test_back_to_back();
    test_reset_mid_req();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wic_pend_arb.md
# wic_pend_arb

Parametrised wake-up interrupt controller: latches up to NUM_INT interrupt lines as level or rising-edge pending bits, and masks them with per-channel wake enables to produce a raw wake indication. It serialises enabled pending interrupts to the core through a valid/ack request channel, and clears each pending bit on acknowledge. It sits in the always-on wic_clk domain between the peripheral interrupt sources and the core's interrupt/wake logic.

## Interface
- NUM_INT, 32, number of interrupt channels (2..64)
- ID_W, derived $clog2(NUM_INT), width of request id (localparam, not overridable)
- wic_clk  in  1  always-on clock; all logic on rising edge
- pad_cpu_rst_b  in  1  reset, asynchronous, active-low
- int_vld  in  NUM_INT  raw interrupt lines
- int_cfg  in  NUM_INT  per channel: 1 = rising-edge (pulse), 0 = level
- int_en  in  NUM_INT  per-channel wake/arbitration enable
- sw_clr  in  NUM_INT  per-channel one-cycle pending clear
- int_pending  out  NUM_INT  pending register
- intraw_vld  out  1  |(int_pending & int_en), combinational from registers
- arb_req_vld  out  1  request to core valid
- arb_req_id  out  ID_W  index of requested channel
- arb_req_ack  in  1  core accepts request

## Operation
- Reset: int_pending=0, edge-history register=0, state IDLE, arb_req_vld=0, arb_req_id=0, intraw_vld=0.
- Edge channel: set when int_vld=1 and history=0; history <= int_vld each cycle. A line already high at reset release sets pending on the first clock.
- Level channel: set every cycle int_vld=1.
- Clear sources: sw_clr[i]; arb_req_ack while in REQ clears bit arb_req_id.
- Same-cycle set and clear: set wins (no lost edge; level channel stays pending while line is high).
- FSM, two states:
  - IDLE: if |(int_pending & int_en) -> REQ, latch arb_req_id = lowest-index set bit of (int_pending & int_en).
  - REQ: arb_req_vld=1, arb_req_id held stable; on arb_req_ack -> IDLE.
- arb_req_ack outside REQ: ignored, no clear.
- In REQ, arb_req_vld/arb_req_id stay stable until ack even if int_en or the pending bit drops (sw_clr); the resulting ack clears an already-clear bit harmlessly.
- int_cfg changes take effect next cycle; existing pending bits are kept.

## Timing
- Input edge/level in cycle N -> int_pending and intraw_vld at N+1.
- Pending visible at N+1 -> arb_req_vld at N+2.
- Ack in cycle M -> pending bit cleared and arb_req_vld=0 at M+1; next request earliest at M+2 (guaranteed one-cycle gap).
- Back-to-back acks therefore give one request per two cycles.
- Reset assertion mid-request: all outputs zero immediately (asynchronous), no ack required.

## Configuration
- WIC_IN_SYNC_EN defined: int_vld passes a 2-flop synchroniser (reset 0) before edge/level detection; input-to-pending latency becomes 3 cycles and input-to-request latency 4 cycles. Use for asynchronous sources.
- Undefined: int_vld is used directly (caller guarantees wic_clk-synchronous inputs); latencies as in Timing.

## Structure
- Package wic_pkg: FSM state typedef (WIC_IDLE, WIC_REQ), id-width function, reset constants.
- Sub-module wic_prio_enc: parametrised lowest-index-first priority encoder (NUM_INT -> ID_W index + any flag), purely combinational, reused by later WIC variants.
- Synchroniser inline under the macro; no further hierarchy.

## Test plan
- Reset release with int_vld[3]=1, int_cfg[3]=1, int_en=0 -> int_pending=0x8 at first clock, intraw_vld=0, arb_req_vld stays 0.
- Set int_en=0xFFFFFFFF; pulse int_vld[5] and int_vld[2] in same cycle N (edge) -> pending=0x24 at N+1; request id 2 at N+2; ack -> id 5 requested two cycles later; second ack -> pending=0.
- Level channel 7 held high, acked -> bit 7 stays pending, re-requested at ack+2; drop line then ack -> pending[7]=0.
- sw_clr[2] pulsed in the same cycle as a new rising edge on channel 2 -> pending[2] remains 1.
- Assert pad_cpu_rst_b low while arb_req_vld=1 -> arb_req_vld, arb_req_id, int_pending all 0 without waiting for a clock.
- NUM_INT=8 with WIC_IN_SYNC_EN: edge on int_vld[7] at N -> pending[7] at N+3, arb_req_vld with id 7 at N+4.
